// File: rtl/dma_ci_bidir.sv
// Custom-instruction front end with a local SSRAM and a burst DMA engine that
// moves blocks between the SSRAM and the system bus in either direction.
module dma_ci_bidir #(
  parameter logic [7:0] customId       = 8'h00,
  parameter int         MEM_ADDR_WIDTH = 9,
  parameter logic [7:0] MAX_BURST      = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  input  logic [31:0] addressDataIn,
  input  logic        endTransactionIn,
  input  logic        dataValidIn,
  input  logic        busErrorIn,
  input  logic        busyIn,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic        readNotWriteOut,
  output logic        beginTransactionOut,
  output logic        endTransactionOut,
  output logic        dataValidOut
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [3:0] {IDLE, INIT, REQ, BEGIN, RDATA, WDATA, WEND, NEXT, ERR} state_t;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  state_t r_state, w_state_next;

  logic [31:0]               r_mem [0:DEPTH-1];
  logic [31:0]               r_ci_q, r_dma_q;
  logic [31:0]               r_cfg_bus;
  logic [MEM_ADDR_WIDTH-1:0] r_cfg_mem;
  logic [9:0]                r_cfg_blk;
  logic [7:0]                r_cfg_burst;
  logic [31:0]               r_bus_addr;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
  logic [9:0]                r_remaining;
  logic [7:0]                r_beats;
  logic                      r_dir_rd, r_error;
  logic                      r_done, r_rd_pend;
  logic [2:0]                r_rd_tgt;
  logic [31:0]               r_result;

  logic                      w_ci_acc, w_ci_wr, w_ci_rd, w_ctrl_go;
  logic [2:0]                w_tgt;
  logic [MEM_ADDR_WIDTH-1:0] w_ci_addr, w_dma_raddr;
  logic                      w_rd_beat, w_wr_beat, w_beat, w_data_err;
  logic [9:0]                w_rem_m1;
  logic [7:0]                w_cap, w_burst;
  logic [31:0]               w_rd_mux;
  logic                      w_unused;

  assign w_ci_acc  = start && (ciN == customId);
  assign w_ci_wr   = w_ci_acc && valueA[9];
  assign w_ci_rd   = w_ci_acc && !valueA[9];
  assign w_tgt     = valueA[12:10];
  assign w_ci_addr = valueA[MEM_ADDR_WIDTH-1:0];
  assign w_ctrl_go = w_ci_wr && (w_tgt == 3'd5) && (r_state == IDLE) &&
                     ((valueB[1:0] == 2'b01) || (valueB[1:0] == 2'b10));
  assign w_unused  = ^valueA;

  assign w_data_err = ((r_state == RDATA) || (r_state == WDATA)) && busErrorIn;
  assign w_rd_beat  = (r_state == RDATA) && dataValidIn && !busErrorIn;
  assign w_wr_beat  = (r_state == WDATA) && !busyIn && !busErrorIn;
  assign w_beat     = w_rd_beat || w_wr_beat;

  assign w_rem_m1 = r_remaining - 10'd1;
  assign w_cap    = (r_cfg_burst < MAX_BURST) ? r_cfg_burst : MAX_BURST;
  assign w_burst  = ({2'b00, w_cap} <= w_rem_m1) ? w_cap : w_rem_m1[7:0];

  // Prefetch the next word on an accepted write beat so r_dma_q always holds mem[r_mem_addr].
  assign w_dma_raddr = w_wr_beat ? r_mem_addr + MEM_ADDR_WIDTH'(1) : r_mem_addr;

  // DMA write is issued last so it wins a same-address collision with the CI.
  always_ff @(posedge clock) begin
    if (w_ci_wr && (w_tgt == 3'd0))
      r_mem[w_ci_addr] <= valueB;
    if (w_rd_beat)
      r_mem[r_mem_addr] <= bswap(addressDataIn);
    r_ci_q  <= r_mem[w_ci_addr];
    r_dma_q <= r_mem[w_dma_raddr];
  end

  always_comb begin
    w_rd_mux = '0;
    case (r_rd_tgt)
      3'd0:    w_rd_mux = r_ci_q;
      3'd1:    w_rd_mux = r_cfg_bus;
      3'd2:    w_rd_mux = {{(32-MEM_ADDR_WIDTH){1'b0}}, r_cfg_mem};
      3'd3:    w_rd_mux = {22'd0, r_cfg_blk};
      3'd4:    w_rd_mux = {24'd0, r_cfg_burst};
      3'd5:    w_rd_mux = {30'd0, r_error, (r_state != IDLE)};
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_done      <= 1'b0;
      r_result    <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_tgt    <= '0;
      r_cfg_bus   <= '0;
      r_cfg_mem   <= '0;
      r_cfg_blk   <= '0;
      r_cfg_burst <= '0;
    end else begin
      r_rd_pend <= w_ci_rd;
      r_rd_tgt  <= w_tgt;
      r_done    <= w_ci_wr || r_rd_pend;
      r_result  <= r_rd_pend ? w_rd_mux : '0;
      if (w_ci_wr) begin
        case (w_tgt)
          3'd1:    r_cfg_bus   <= valueB;
          3'd2:    r_cfg_mem   <= valueB[MEM_ADDR_WIDTH-1:0];
          3'd3:    r_cfg_blk   <= valueB[9:0];
          3'd4:    r_cfg_burst <= valueB[7:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_dir_rd    <= 1'b0;
      r_error     <= 1'b0;
      r_bus_addr  <= '0;
      r_mem_addr  <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ctrl_go) begin
        r_dir_rd <= (valueB[1:0] == 2'b01);
        r_error  <= 1'b0;
      end
      if (w_data_err)
        r_error <= 1'b1;
      if (r_state == INIT) begin
        r_bus_addr  <= r_cfg_bus;
        r_mem_addr  <= r_cfg_mem;
        r_remaining <= r_cfg_blk;
      end
      if (r_state == BEGIN)
        r_beats <= w_burst;
      if (w_beat) begin
        r_mem_addr <= r_mem_addr + MEM_ADDR_WIDTH'(1);
        r_bus_addr <= r_bus_addr + 32'd4;
        if (r_remaining != 10'd0)
          r_remaining <= r_remaining - 10'd1;
        if (r_beats != 8'd0)
          r_beats <= r_beats - 8'd1;
      end
    end
  end

  always_comb begin
    w_state_next        = r_state;
    requestTransaction  = 1'b0;
    addressDataOut      = '0;
    byteEnablesOut      = '0;
    burstSizeOut        = '0;
    readNotWriteOut     = 1'b0;
    beginTransactionOut = 1'b0;
    endTransactionOut   = 1'b0;
    dataValidOut        = 1'b0;
    case (r_state)
      IDLE: if (w_ctrl_go) w_state_next = INIT;
      INIT: w_state_next = (r_cfg_blk == 10'd0) ? IDLE : REQ;
      REQ: begin
        requestTransaction = 1'b1;
        if (transactionGranted) w_state_next = BEGIN;
      end
      BEGIN: begin
        beginTransactionOut = 1'b1;
        addressDataOut      = r_bus_addr;
        byteEnablesOut      = 4'hF;
        readNotWriteOut     = r_dir_rd;
        burstSizeOut        = w_burst;
        w_state_next        = r_dir_rd ? RDATA : WDATA;
      end
      RDATA: begin
        if (busErrorIn)            w_state_next = endTransactionIn ? IDLE : ERR;
        else if (endTransactionIn) w_state_next = NEXT;
      end
      WDATA: begin
        if (busErrorIn) begin
          w_state_next = endTransactionIn ? IDLE : ERR;
        end else begin
          dataValidOut   = 1'b1;
          addressDataOut = bswap(r_dma_q);
          if (!busyIn && (r_beats == 8'd0)) w_state_next = WEND;
        end
      end
      WEND: begin
        endTransactionOut = 1'b1;
        w_state_next      = NEXT;
      end
      NEXT: w_state_next = (r_remaining == 10'd0) ? IDLE : REQ;
      ERR:  if (endTransactionIn) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_dma_ci_bidir.sv
// Randomized bench for dma_ci_bidir: a CI driver, a bus slave, and a plain
// array model of the SSRAM that predicts every word moved by the DMA.
module tb_dma_ci_bidir;

  localparam logic [7:0] CI_ID = 8'h2A;
  localparam int         MASK  = 511;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB;
  logic        done;
  logic [31:0] result;
  logic        requestTransaction, transactionGranted;
  logic [31:0] addressDataIn;
  logic        endTransactionIn, dataValidIn, busErrorIn, busyIn;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut;

  dma_ci_bidir #(.customId(CI_ID), .MEM_ADDR_WIDTH(9), .MAX_BURST(8'd255)) dut (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB), .done(done), .result(result),
    .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
    .addressDataIn(addressDataIn), .endTransactionIn(endTransactionIn),
    .dataValidIn(dataValidIn), .busErrorIn(busErrorIn), .busyIn(busyIn),
    .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
    .burstSizeOut(burstSizeOut), .readNotWriteOut(readNotWriteOut),
    .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
    .dataValidOut(dataValidOut)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Free-running bus monitors; scenarios take differences of snapshots.
  int mon_req = 0, mon_beats = 0, mon_end = 0;
  always @(negedge clock) begin
    if (requestTransaction) mon_req++;
    if (dataValidOut && !busyIn) mon_beats++;
    if (endTransactionOut) mon_end++;
  end

  logic [31:0] mm [512];
  logic [31:0] m_bus;
  int          m_mem, m_blk, m_burst;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] out_vec();
    return {14'd0, done, requestTransaction, beginTransactionOut, endTransactionOut,
            dataValidOut, readNotWriteOut, byteEnablesOut, burstSizeOut};
  endfunction

  task automatic ci_write(input logic [2:0] tgt, input logic [8:0] addr, input logic [31:0] data);
    start = 1'b1; ciN = CI_ID; valueA = {19'd0, tgt, 1'b1, addr}; valueB = data;
    tick;
    check("ci_wr_done", 32'(done), 32'd1);
    check("ci_wr_result", result, 32'd0);
    start = 1'b0; valueA = '0; valueB = '0;
  endtask

  task automatic ci_read(input logic [2:0] tgt, input logic [8:0] addr, output logic [31:0] r);
    start = 1'b1; ciN = CI_ID; valueA = {19'd0, tgt, 1'b0, addr}; valueB = '0;
    tick;
    start = 1'b0; valueA = '0;
    check("ci_rd_not_early", 32'(done), 32'd0);
    tick;
    check("ci_rd_done", 32'(done), 32'd1);
    r = result;
    tick;
    check("ci_rd_after", {31'd0, done} | result, 32'd0);
  endtask

  task automatic cfg(input logic [31:0] bus, input int mem, input int blk, input int burst);
    m_bus = bus; m_mem = mem & MASK; m_blk = blk & 10'h3FF; m_burst = burst & 8'hFF;
    ci_write(3'd1, 9'd0, bus);
    ci_write(3'd2, 9'd0, 32'(mem));
    ci_write(3'd3, 9'd0, 32'(blk));
    ci_write(3'd4, 9'd0, 32'(burst));
  endtask

  task automatic wait_req;
    for (int n = 0; n < 16 && !requestTransaction; n++) tick;
    check("req_seen", 32'(requestTransaction), 32'd1);
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] r;
    ci_read(3'd5, 9'd0, r);
    check(tag, r, exp);
  endtask

  task automatic check_mem(input int base, input int cnt);
    logic [31:0] r;
    for (int j = 0; j < cnt; j++) begin
      ci_read(3'd0, 9'((base + j) & MASK), r);
      check("ssram_word", r, mm[(base + j) & MASK]);
    end
  endtask

  // Plays the bus slave for a whole transfer using the configured m_* values.
  task automatic run_dma(input bit rd, input int busy_beat, input int busy_len, input int err_beat);
    int rem, mem, nb, gb;
    logic [31:0] bus, d, exp;
    rem = m_blk; bus = m_bus; mem = m_mem; gb = 0;
    while (rem > 0) begin
      wait_req;
      if (!requestTransaction) return;
      transactionGranted = 1'b1;
      tick;
      transactionGranted = 1'b0;
      nb = (m_burst < rem - 1) ? m_burst : rem - 1;
      check("begin_pulse", 32'(beginTransactionOut), 32'd1);
      check("begin_addr", addressDataOut, bus);
      check("begin_burst", 32'(burstSizeOut), 32'(nb));
      check("begin_rnw", 32'(readNotWriteOut), 32'(rd));
      check("begin_be", 32'(byteEnablesOut), 32'hF);
      $display("burst %s addr=0x%08h beats=%0d", rd ? "rd" : "wr", bus, nb + 1);
      tick;
      for (int i = 0; i <= nb; i++) begin
        if (rd) begin
          if (gb == err_beat) begin
            busErrorIn = 1'b1; dataValidIn = 1'b0; endTransactionIn = 1'b0;
            tick;
            busErrorIn = 1'b0;
            return;
          end
          d = $urandom;
          addressDataIn = d; dataValidIn = 1'b1; endTransactionIn = (i == nb);
          mm[(mem + i) & MASK] = bswap(d);
          tick;
        end else begin
          exp = bswap(mm[(mem + i) & MASK]);
          check("wr_valid", 32'(dataValidOut), 32'd1);
          check("wr_data", addressDataOut, exp);
          if (gb == busy_beat) begin
            for (int k = 0; k < busy_len; k++) begin
              busyIn = 1'b1;
              tick;
              check("wr_busy_valid", 32'(dataValidOut), 32'd1);
              check("wr_busy_hold", addressDataOut, exp);
            end
            busyIn = 1'b0;
          end
          tick;
        end
        gb++;
      end
      dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
      if (!rd) begin
        check("wr_end_pulse", 32'(endTransactionOut), 32'd1);
        tick;
      end
      rem -= nb + 1;
      bus += 32'(4 * (nb + 1));
      mem += nb + 1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int b0, e0, q0, a;
    reset = 1'b0; start = 1'b0; ciN = '0; valueA = '0; valueB = '0;
    transactionGranted = 1'b0; addressDataIn = '0; endTransactionIn = 1'b0;
    dataValidIn = 1'b0; busErrorIn = 1'b0; busyIn = 1'b0;
    repeat (3) tick;
    check("reset_outputs", out_vec(), 32'd0);
    check("reset_bus_data", addressDataOut, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b1;
    tick;
    check_status("status_after_reset", 32'd0);

    // Basic SSRAM write/read, and a foreign CI number must be ignored.
    ci_write(3'd0, 9'd5, 32'h12345678);
    mm[5] = 32'h12345678;
    start = 1'b1; ciN = CI_ID + 8'd1; valueA = {19'd0, 3'd0, 1'b1, 9'd5}; valueB = 32'hDEADBEEF;
    tick;
    check("foreign_ci_done", 32'(done), 32'd0);
    start = 1'b0; valueA = '0; valueB = '0;
    tick;
    ci_read(3'd0, 9'd5, r);
    check("ssram5", r, 32'h12345678);
    $display("ci ssram[5] read 0x%08h", r);

    for (int i = 0; i < 512; i++) begin
      mm[i] = $urandom;
      ci_write(3'd0, 9'(i), mm[i]);
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 511);
      ci_read(3'd0, 9'(a), r);
      check("ssram_rand", r, mm[a]);
    end

    // Config readback, including the unused targets.
    cfg(32'h100, 0, 6, 3);
    ci_read(3'd1, 9'd0, r); check("cfg_bus", r, 32'h100);
    ci_read(3'd2, 9'd0, r); check("cfg_mem", r, 32'd0);
    ci_read(3'd3, 9'd0, r); check("cfg_blk", r, 32'd6);
    ci_read(3'd4, 9'd0, r); check("cfg_burst", r, 32'd3);
    ci_write(3'd6, 9'd0, 32'hFFFF_FFFF);
    ci_read(3'd6, 9'd0, r); check("tgt6_zero", r, 32'd0);
    ci_read(3'd7, 9'd0, r); check("tgt7_zero", r, 32'd0);

    // Read DMA: two bursts of 4 and 2 beats.
    ci_write(3'd5, 9'd0, 32'd1);
    run_dma(1'b1, -1, 0, -1);
    check_status("status_after_rd", 32'd0);
    check_mem(0, 6);

    // Write DMA with busy stall on the second beat.
    cfg(32'h2000, 10, 3, 7);
    b0 = mon_beats; e0 = mon_end;
    ci_write(3'd5, 9'd0, 32'd2);
    run_dma(1'b0, 1, 2, -1);
    check("wr_beat_count", 32'(mon_beats - b0), 32'd3);
    check("wr_end_count", 32'(mon_end - e0), 32'd1);
    check_status("status_after_wr", 32'd0);

    // Block size zero and an invalid control word never reach the bus.
    cfg(32'h40, 0, 0, 3);
    q0 = mon_req;
    ci_write(3'd5, 9'd0, 32'd1);
    check_status("status_blk0", 32'd0);
    cfg(32'h40, 0, 4, 3);
    ci_write(3'd5, 9'd0, 32'd3);
    check_status("status_ctrl11", 32'd0);
    check("no_request", 32'(mon_req - q0), 32'd0);

    // Bus error on the second read beat, without an end marker.
    cfg(32'h300, 20, 4, 3);
    ci_write(3'd5, 9'd0, 32'd1);
    run_dma(1'b1, -1, 0, 1);
    check("err_no_req", 32'(requestTransaction), 32'd0);
    check_status("status_err_busy", 32'd3);
    endTransactionIn = 1'b1;
    tick;
    endTransactionIn = 1'b0;
    check_status("status_err_idle", 32'd2);
    check_mem(20, 1);

    // Random transfers; the first accepted start also clears the sticky error.
    for (int it = 0; it < 4; it++) begin
      bit rd;
      rd = 1'(it[0] ^ 1'($urandom_range(0, 1)));
      cfg({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, (it == 0) ? 508 : $urandom_range(0, 511),
          $urandom_range(1, 10), $urandom_range(0, 4));
      ci_write(3'd5, 9'd0, rd ? 32'd1 : 32'd2);
      run_dma(rd, $urandom_range(0, 3), $urandom_range(1, 3), -1);
      check_status("status_rand", 32'd0);
      if (rd) check_mem(m_mem, m_blk);
    end

    // Reset in the middle of a read burst.
    cfg(32'h400, 40, 8, 7);
    ci_write(3'd5, 9'd0, 32'd1);
    wait_req;
    transactionGranted = 1'b1;
    tick;
    transactionGranted = 1'b0;
    tick;
    addressDataIn = $urandom; dataValidIn = 1'b1;
    tick;
    dataValidIn = 1'b0; addressDataIn = '0;
    reset = 1'b0;
    #1;
    check("midreset_outputs", out_vec(), 32'd0);
    check("midreset_bus_data", addressDataOut, 32'd0);
    q0 = mon_req;
    tick; tick;
    reset = 1'b1;
    repeat (4) tick;
    check("post_reset_quiet", 32'(mon_req - q0), 32'd0);
    check_status("status_post_reset", 32'd0);
    ci_read(3'd3, 9'd0, r); check("cfg_blk_reset", r, 32'd0);
    cfg(32'h500, 50, 5, 2);
    ci_write(3'd5, 9'd0, 32'd1);
    run_dma(1'b1, -1, 0, -1);
    check_status("status_final", 32'd0);
    check_mem(50, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_ci_bidir.md
DMA_CI_BIDIR -- requirements
Module: dma_ci_bidir

Interface
REQ-001 SHALL have parameter customId, default 8'h00, the CI number the block answers to.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 9, range 4..9, giving local SSRAM depth 2^MEM_ADDR_WIDTH x 32 bit.
REQ-003 SHALL have parameter MAX_BURST, default 8'd255, a cap on burst beats minus one.
REQ-004 SHALL have these ports (name dir width meaning):
- clock in 1: single clock; all logic on the rising edge.
- reset in 1: asynchronous, active-low.
- start in 1: CI start. ciN in 8: CI number. valueA, valueB in 32: CI operands.
- done out 1: CI complete. result out 32: CI read data.
- requestTransaction out 1, transactionGranted in 1: arbiter handshake.
- addressDataIn in 32, endTransactionIn in 1, dataValidIn in 1, busErrorIn in 1, busyIn in 1: bus inputs.
- addressDataOut out 32, byteEnablesOut out 4, burstSizeOut out 8, readNotWriteOut out 1, beginTransactionOut out 1, endTransactionOut out 1, dataValidOut out 1: bus master outputs.

Function
REQ-005 SHALL accept a CI only when start=1 and ciN==customId; valueA[9] is the write flag, valueA[12:10] selects the target, and valueA[MEM_ADDR_WIDTH-1:0] is the SSRAM address.
REQ-006 SHALL decode targets as: 0 SSRAM word, 1 bus start address (32b), 2 memory start address, 3 block size (10b), 4 burst size (8b), 5 control (write) / status (read); targets 6 and 7 write nothing and read 0.
REQ-007 For a CI write, SHALL pulse done high for one cycle, one cycle after start, with result=0.
REQ-008 For a CI read, SHALL pulse done high for one cycle, two cycles after start, with result valid only in that cycle and 0 otherwise.
REQ-009 Writing control=2'b01 while idle SHALL start a bus-to-SSRAM transfer; 2'b10 SHALL start an SSRAM-to-bus transfer; 2'b00, 2'b11, or any write while busy SHALL be ignored.
REQ-010 Status SHALL read as {30'b0, error, busy}; busy=1 whenever the FSM is not IDLE; error is sticky until reset or the next accepted start.
REQ-011 SHALL use FSM states IDLE, INIT, REQ, BEGIN, RDATA, WDATA, WEND, NEXT, ERR.
REQ-012 FSM transitions SHALL be:
- IDLE->INIT on an accepted start.
- INIT latches addresses and remaining=block size, then goes to REQ; if block size is 0, it goes to IDLE instead.
- REQ->BEGIN on transactionGranted.
- BEGIN->RDATA (read) or WDATA (write).
REQ-013 In BEGIN, SHALL drive for one cycle: beginTransactionOut=1, addressDataOut=bus address, byteEnablesOut=4'hF, readNotWriteOut=1 for a read, and burstSizeOut=min(burst size, MAX_BURST, remaining-1).
REQ-014 In RDATA, each dataValidIn beat SHALL write the byte-swapped addressDataIn to SSRAM at the current memory address, then increment the memory address by 1 (wrapping modulo depth), increment the bus address by 4, and decrement remaining by 1.
REQ-015 In RDATA, endTransactionIn SHALL move the FSM to NEXT.
REQ-016 In WDATA, SHALL present byte-swapped SSRAM words with dataValidOut=1, advancing the counters only on cycles with busyIn=0.
REQ-017 After the last beat of a write burst, WDATA SHALL go to WEND, which asserts endTransactionOut for one cycle and then goes to NEXT.
REQ-018 NEXT SHALL go to IDLE if remaining==0, else to REQ.
REQ-019 busErrorIn in RDATA or WDATA SHALL set error, deassert dataValidOut, and go to ERR; if endTransactionIn is high in the same cycle, it SHALL go straight to IDLE. ERR SHALL go to IDLE on endTransactionIn.
REQ-020 requestTransaction SHALL be 1 only in REQ; all bus outputs SHALL be 0 outside their active states.
REQ-021 On a same-cycle, same-address SSRAM write from the CI and from the DMA, the DMA data SHALL win.

Reset
REQ-022 reset=0 SHALL immediately force IDLE, all outputs to 0, all config registers, counters and status to 0, and error cleared; SSRAM contents are undefined after reset.
REQ-023 reset asserted mid-transfer SHALL abort with no further bus activity; after release, the block SHALL accept a new start.

Verification
REQ-024 The bench SHALL cover these scenarios:
- CI write SSRAM[5]=0x12345678, then CI read target 0 addr 5 -> done two cycles after start, result=0x12345678.
- Read DMA, block 6, burst 3, bus 0x100, mem 0 -> two bursts with burstSizeOut=3 then 1, addresses 0x100 and 0x110, SSRAM[0..5] byte-swapped, then status=0.
- Write DMA, block 3, busyIn held for 2 cycles on beat 2 -> exactly 3 dataValidOut beats, data unchanged during busy, one endTransactionOut pulse.
- Block size 0 -> requestTransaction never asserted, busy returns to 0 within 3 cycles.
- busErrorIn on beat 2 without endTransactionIn -> ERR, status=2'b11 until endTransactionIn, then status=2'b10.
- reset pulsed during RDATA -> all outputs 0 the same cycle, status=0, next transfer completes normally.
